// File: rtl/vec_wb_queue.sv
// Vector writeback queue: buffers {addr, data} results from a vector
// producer and drains them in order into the vector register file write
// port, stalling on wb_stall. Pending writes are visible to a consumer
// through a youngest-match forwarding port.
module vec_wb_queue #(
   parameter int VECTOR_REGS = 32,
   parameter int VEC_WIDTH   = 512,
   parameter int DEPTH       = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [$clog2(VECTOR_REGS)-1:0] in_addr,
   input  logic [VEC_WIDTH-1:0]           in_data,
   input  logic                           wb_stall,
   output logic                           v_write_enable,
   output logic [$clog2(VECTOR_REGS)-1:0] v_write_reg_addr,
   output logic [VEC_WIDTH-1:0]           v_write_data,
   input  logic [$clog2(VECTOR_REGS)-1:0] fwd_addr,
   output logic                           fwd_hit,
   output logic [VEC_WIDTH-1:0]           fwd_data,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int AW = $clog2(VECTOR_REGS);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Entry storage holds data only; occupancy comes from head/count, so
   // these arrays need no reset.
   logic [AW-1:0]        addr_q [DEPTH];
   logic [VEC_WIDTH-1:0] data_q [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic push, pop, not_empty;

   assign not_empty      = (count_q != '0);
   // No push-through when full: a same-cycle pop does not open a slot.
   assign in_ready       = (count_q < FULL);
   assign push           = in_valid && in_ready;
   assign v_write_enable = not_empty && !wb_stall;
   assign pop            = v_write_enable;
   assign count          = count_q;

   // Head entry drives the write port; zeroed when nothing is queued.
   always_comb begin
      v_write_reg_addr = '0;
      v_write_data     = '0;
      if (not_empty) begin
         v_write_reg_addr = addr_q[head_q];
         v_write_data     = data_q[head_q];
      end
   end

   // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards all queued entries immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Capture the accepted offer into the tail slot.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= in_addr;
         data_q[tail_q] <= in_data;
      end
   end

   // Forwarding scan from oldest to youngest so the last match wins. The
   // entry being pushed this cycle is not yet in storage and is not seen.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if ((CW'(k) < count_q) && (addr_q[idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end

endmodule

// File: tb/tb_vec_wb_queue.sv
// Directed bench for vec_wb_queue: each task drives one scenario and checks
// the outputs against hand-computed values mid-cycle.
module tb_vec_wb_queue;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   in_addr;
   logic [511:0] in_data;
   logic         wb_stall;
   logic         v_write_enable;
   logic [4:0]   v_write_reg_addr;
   logic [511:0] v_write_data;
   logic [4:0]   fwd_addr;
   logic         fwd_hit;
   logic [511:0] fwd_data;
   logic [2:0]   count;

   int checks   = 0;
   int failures = 0;

   vec_wb_queue #(.VECTOR_REGS(32), .VEC_WIDTH(512), .DEPTH(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_addr          (in_addr),
      .in_data          (in_data),
      .wb_stall         (wb_stall),
      .v_write_enable   (v_write_enable),
      .v_write_reg_addr (v_write_reg_addr),
      .v_write_data     (v_write_data),
      .fwd_addr         (fwd_addr),
      .fwd_hit          (fwd_hit),
      .fwd_data         (fwd_data),
      .count            (count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   function automatic logic [511:0] pat(input logic [7:0] b);
      return {64{b}};
   endfunction

   // Advance past the next rising edge; inputs are changed just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
      wb_stall = 1'b0; fwd_addr = '0;
      #3;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      checks++; if (v_write_enable !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", v_write_enable); end
      checks++; if (v_write_reg_addr !== 5'd0) begin failures++; $display("FAIL rst_waddr got=%0d exp=0", v_write_reg_addr); end
      checks++; if (v_write_data !== '0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", v_write_data); end
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin failures++; $display("FAIL rst_fwd got=%b/%h exp=0/0", fwd_hit, fwd_data); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
      // Offers during reset must be ignored.
      in_valid = 1'b1; in_addr = 5'd3; in_data = pat(8'h33);
      tick(); tick();
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++; if (count !== 3'd0 || in_ready !== 1'b1 || v_write_enable !== 1'b0) begin failures++; $display("FAIL post_rst got=cnt%0d rdy%b we%b exp=cnt0 rdy1 we0", count, in_ready, v_write_enable); end
   endtask

   task automatic test_single_write();
      tick();
      in_valid = 1'b1; in_addr = 5'd5; in_data = pat(8'hA5); fwd_addr = 5'd5;
      #1;
      checks++; if (fwd_hit !== 1'b0) begin failures++; $display("FAIL single_fwd_pushing got=%b exp=0", fwd_hit); end
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
      checks++; if (v_write_enable !== 1'b1 || v_write_reg_addr !== 5'd5) begin failures++; $display("FAIL single_write got=we%b addr%0d exp=we1 addr5", v_write_enable, v_write_reg_addr); end
      checks++; if (v_write_data !== pat(8'hA5)) begin failures++; $display("FAIL single_data got=%h exp=%h", v_write_data, pat(8'hA5)); end
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== pat(8'hA5)) begin failures++; $display("FAIL single_fwd got=%b/%h exp=1/a5", fwd_hit, fwd_data); end
      tick();
      checks++; if (count !== 3'd0 || v_write_enable !== 1'b0 || v_write_reg_addr !== 5'd0 || v_write_data !== '0) begin failures++; $display("FAIL single_empty got=cnt%0d we%b addr%0d exp=cnt0 we0 addr0", count, v_write_enable, v_write_reg_addr); end
   endtask

   task automatic test_fill();
      wb_stall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; in_addr = 5'(i); in_data = pat(8'(i));
         tick();
      end
      in_addr = 5'd15; in_data = pat(8'hFF);
      #1;
      checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin failures++; $display("FAIL fill_full got=cnt%0d rdy%b exp=cnt4 rdy0", count, in_ready); end
      checks++; if (v_write_enable !== 1'b0 || v_write_reg_addr !== 5'd1) begin failures++; $display("FAIL fill_head got=we%b addr%0d exp=we0 addr1", v_write_enable, v_write_reg_addr); end
      tick();
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth got=%0d exp=4", count); end
      wb_stall = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_no_pushthrough got=%b exp=0", in_ready); end
      in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++; if (v_write_enable !== 1'b1 || v_write_reg_addr !== 5'(i) || v_write_data !== pat(8'(i))) begin failures++; $display("FAIL fill_drain%0d got=we%b addr%0d exp=we1 addr%0d", i, v_write_enable, v_write_reg_addr, i); end
         tick();
      end
      #1;
      checks++; if (count !== 3'd0 || v_write_enable !== 1'b0) begin failures++; $display("FAIL fill_done got=cnt%0d we%b exp=cnt0 we0", count, v_write_enable); end
   endtask

   task automatic test_forwarding();
      wb_stall = 1'b1; fwd_addr = 5'd7;
      in_valid = 1'b1; in_addr = 5'd7; in_data = pat(8'h11);
      tick();
      in_data = pat(8'h22);
      #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== pat(8'h11)) begin failures++; $display("FAIL fwd_excl_push got=%b/%h exp=1/11", fwd_hit, fwd_data); end
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== pat(8'h22)) begin failures++; $display("FAIL fwd_youngest got=%b/%h exp=1/22", fwd_hit, fwd_data); end
      fwd_addr = 5'd8;
      #1;
      checks++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin failures++; $display("FAIL fwd_miss got=%b/%h exp=0/0", fwd_hit, fwd_data); end
      fwd_addr = 5'd7; wb_stall = 1'b0;
      #1;
      checks++; if (v_write_reg_addr !== 5'd7 || v_write_data !== pat(8'h11) || fwd_data !== pat(8'h22)) begin failures++; $display("FAIL fwd_drain1 got=addr%0d data%h exp=addr7 data11", v_write_reg_addr, v_write_data); end
      tick();
      checks++; if (v_write_enable !== 1'b1 || v_write_data !== pat(8'h22) || fwd_hit !== 1'b1) begin failures++; $display("FAIL fwd_drain2 got=we%b data%h exp=we1 data22", v_write_enable, v_write_data); end
      tick();
      checks++; if (count !== 3'd0 || fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_empty got=cnt%0d hit%b exp=cnt0 hit0", count, fwd_hit); end
   endtask

   task automatic test_back_to_back();
      wb_stall = 1'b1;
      for (int i = 10; i <= 11; i++) begin
         in_valid = 1'b1; in_addr = 5'(i); in_data = pat(8'(i));
         tick();
      end
      wb_stall = 1'b0;
      for (int j = 0; j < 10; j++) begin
         in_addr = 5'(12 + j); in_data = pat(8'(12 + j));
         #1;
         checks++; if (count !== 3'd2 || v_write_enable !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ctl%0d got=cnt%0d we%b rdy%b exp=cnt2 we1 rdy1", j, count, v_write_enable, in_ready); end
         checks++; if (v_write_reg_addr !== 5'(10 + j) || v_write_data !== pat(8'(10 + j))) begin failures++; $display("FAIL b2b_order%0d got=%0d exp=%0d", j, v_write_reg_addr, 10 + j); end
         tick();
      end
      in_valid = 1'b0;
      for (int j = 20; j <= 21; j++) begin
         #1;
         checks++; if (v_write_enable !== 1'b1 || v_write_reg_addr !== 5'(j) || v_write_data !== pat(8'(j))) begin failures++; $display("FAIL b2b_tail%0d got=%0d exp=%0d", j, v_write_reg_addr, j); end
         tick();
      end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", count); end
   endtask

   task automatic test_stall_hold();
      wb_stall = 1'b1;
      in_valid = 1'b1; in_addr = 5'd9; in_data = pat(8'h99);
      tick();
      in_valid = 1'b0; in_addr = 5'd4; in_data = pat(8'h44);
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++; if (v_write_enable !== 1'b0 || v_write_reg_addr !== 5'd9 || v_write_data !== pat(8'h99) || count !== 3'd1) begin failures++; $display("FAIL stall_hold%0d got=we%b addr%0d cnt%0d exp=we0 addr9 cnt1", c, v_write_enable, v_write_reg_addr, count); end
         tick();
      end
      wb_stall = 1'b0;
      #1;
      checks++; if (v_write_enable !== 1'b1 || v_write_reg_addr !== 5'd9) begin failures++; $display("FAIL stall_release got=we%b addr%0d exp=we1 addr9", v_write_enable, v_write_reg_addr); end
      tick();
      checks++; if (v_write_enable !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL stall_single got=we%b cnt%0d exp=we0 cnt0", v_write_enable, count); end
   endtask

   task automatic test_reset_mid_drain();
      wb_stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1; in_addr = 5'(i); in_data = pat(8'(i));
         tick();
      end
      in_valid = 1'b0; wb_stall = 1'b0;
      #1;
      checks++; if (v_write_enable !== 1'b1 || count !== 3'd3) begin failures++; $display("FAIL mid_pre got=we%b cnt%0d exp=we1 cnt3", v_write_enable, count); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (v_write_enable !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || v_write_reg_addr !== 5'd0) begin failures++; $display("FAIL mid_async got=we%b cnt%0d rdy%b exp=we0 cnt0 rdy1", v_write_enable, count, in_ready); end
      tick(); tick();
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (v_write_enable !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL mid_nowrite%0d got=we%b cnt%0d exp=we0 cnt0", c, v_write_enable, count); end
         tick();
      end
      // First edge after deassertion must accept a push.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      in_valid = 1'b1; in_addr = 5'd6; in_data = pat(8'h66);
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd1 || v_write_reg_addr !== 5'd6) begin failures++; $display("FAIL first_push got=cnt%0d addr%0d exp=cnt1 addr6", count, v_write_reg_addr); end
      tick();
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL first_drain got=%0d exp=0", count); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill();
      test_forwarding();
      test_back_to_back();
      test_stall_hold();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
